// File: rtl/m_chk_pkg.sv
// m_chk_pkg: state encoding and PN15 generator constants shared by the checker.
// The M_CHK_FLYWHEEL_EN build option lives in m_chk.sv; nothing here depends on it.
package m_chk_pkg;
   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      CHECK = 2'd1,
      LOCK  = 2'd2
   } state_t;

   localparam int                   PN_ORDER = 4;
   localparam logic [PN_ORDER-1:0]  PN_SEED  = 4'b1111;
   localparam int                   TAP_A    = 3;
   localparam int                   TAP_B    = 0;
endpackage

// File: rtl/m_chk_pred.sv
// m_pred: local PN15 history register and next-bit prediction.
// h0 is the oldest bit; new bits enter at the top.
module m_pred
   import m_chk_pkg::*;
(
   input  logic clk,
   input  logic shift_i,
   input  logic sel_i,
   input  logic clear_i,
   input  logic din_i,
   output logic p_o,
   output logic nz_o
);
   logic [PN_ORDER-1:0] h_q, h_d;

   assign p_o  = h_q[TAP_A] ^ h_q[TAP_B];
   // Non-zero test on the history as it will look once din_i is shifted in.
   assign nz_o = din_i | (|h_q[PN_ORDER-1:1]);

   always_comb begin
      h_d = h_q;
      if (clear_i) begin
         h_d = '0;
      end else if (shift_i) begin
         h_d = {(sel_i ? p_o : din_i), h_q[PN_ORDER-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      h_q <= h_d;
   end
endmodule

// File: rtl/m_chk.sv
// m_chk: self-synchronising PN15 receive checker with lock detection and error count.
// Define M_CHK_FLYWHEEL_EN to free-run the local generator while locked.
module m_chk
   import m_chk_pkg::*;
#(
   parameter int LOCK_CNT = 8,
   parameter int WIN      = 15,
   parameter int ERR_MAX  = 4,
   parameter int CW       = 16
) (
   input  logic          clk,
   input  logic          res,
   input  logic          din,
   input  logic          din_vld,
   input  logic          clr,
   output logic          lock,
   output logic          err,
   output logic [CW-1:0] err_cnt
);
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int WW = $clog2(WIN + 1);
   localparam int EW = $clog2(ERR_MAX + 1);

   state_t          state_q, state_d;
   logic [1:0]      hcnt_q, hcnt_d;
   logic [MW-1:0]   mcnt_q, mcnt_d;
   logic [WW-1:0]   wcnt_q, wcnt_d;
   logic [EW-1:0]   werr_q, werr_d;
   logic [CW-1:0]   ecnt_q, ecnt_d;
   logic            lock_q, lock_d;
   logic            err_q, err_d;
   logic            p, nz, miss, fly;
   logic            hunt_done, check_done, lose;

`ifdef M_CHK_FLYWHEEL_EN
   assign fly = (state_q == LOCK);
`else
   assign fly = 1'b0;
`endif

   m_pred u_pred (
      .clk     (clk),
      .shift_i (din_vld),
      .sel_i   (fly),
      .clear_i (!res || lose),
      .din_i   (din),
      .p_o     (p),
      .nz_o    (nz)
   );

   assign miss       = din ^ p;
   // The all-zero history is the degenerate PN state and must never be tracked.
   assign hunt_done  = (state_q == HUNT) && din_vld && (hcnt_q == 2'd3) && nz;
   assign check_done = (state_q == CHECK) && din_vld && !miss && (mcnt_q == MW'(LOCK_CNT - 1));
   assign lose       = (state_q == LOCK) && din_vld && miss && (werr_q == EW'(ERR_MAX - 1));

   always_ff @(posedge clk) begin
      if (!res) state_q <= HUNT;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HUNT:    if (hunt_done)  state_d = CHECK;
         CHECK:   if (check_done) state_d = LOCK;
         LOCK:    if (lose)       state_d = HUNT;
         default:                 state_d = HUNT;
      endcase
   end

   always_comb begin
      lock_d = (state_d == LOCK);
      err_d  = (state_q == LOCK) && din_vld && miss;
   end

   always_comb begin
      hcnt_d = hcnt_q;
      mcnt_d = mcnt_q;
      wcnt_d = wcnt_q;
      werr_d = werr_q;
      ecnt_d = ecnt_q;
      if (din_vld) begin
         case (state_q)
            HUNT: begin
               if (hcnt_q != 2'd3) hcnt_d = hcnt_q + 2'd1;
               if (hunt_done)      hcnt_d = '0;
            end
            CHECK: begin
               mcnt_d = miss ? '0 : mcnt_q + MW'(1);
               if (check_done) begin
                  mcnt_d = '0;
                  wcnt_d = '0;
                  werr_d = '0;
               end
            end
            LOCK: begin
               if (miss && (ecnt_q != {CW{1'b1}})) ecnt_d = ecnt_q + CW'(1);
               // Losing lock outranks the window wrap on the same bit.
               if (lose) begin
                  wcnt_d = '0;
                  werr_d = '0;
               end else if (wcnt_q == WW'(WIN - 1)) begin
                  wcnt_d = '0;
                  werr_d = '0;
               end else begin
                  wcnt_d = wcnt_q + WW'(1);
                  werr_d = werr_q + EW'(miss);
               end
            end
            default: ;
         endcase
      end
      if (clr) ecnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         hcnt_q <= '0;
         mcnt_q <= '0;
         wcnt_q <= '0;
         werr_q <= '0;
         ecnt_q <= '0;
         lock_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         hcnt_q <= hcnt_d;
         mcnt_q <= mcnt_d;
         wcnt_q <= wcnt_d;
         werr_q <= werr_d;
         ecnt_q <= ecnt_d;
         lock_q <= lock_d;
         err_q  <= err_d;
      end
   end

   assign lock    = lock_q;
   assign err     = err_q;
   assign err_cnt = ecnt_q;
endmodule

// File: tb/tb_m_chk.sv
// tb_m_chk: scoreboard bench for the PN15 checker; a per-bit behavioural model
// predicts lock/err/err_cnt for every clock edge, a monitor compares after the edge.
module tb_m_chk;
   localparam int LOCK_CNT = 8;
   localparam int WIN      = 15;
   localparam int ERR_MAX  = 4;
   localparam int CW       = 16;
   localparam int CNT_MAX  = 65535;
`ifdef M_CHK_FLYWHEEL_EN
   localparam bit FLY = 1'b1;
`else
   localparam bit FLY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          res = 1'b0;
   logic          din = 1'b0;
   logic          din_vld = 1'b0;
   logic          clr = 1'b0;
   logic          lock, err;
   logic [CW-1:0] err_cnt;

   m_chk #(.LOCK_CNT(LOCK_CNT), .WIN(WIN), .ERR_MAX(ERR_MAX), .CW(CW)) dut (
      .clk     (clk),
      .res     (res),
      .din     (din),
      .din_vld (din_vld),
      .clr     (clr),
      .lock    (lock),
      .err     (err),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit lock;
      bit err;
      int cnt;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference sequence straight from the recurrence b[n+4] = b[n+3] ^ b[n].
   bit   pn[15];
   int   gi = 0;

   function automatic bit gen_bit();
      bit b;
      b  = pn[gi % 15];
      gi = gi + 1;
      return b;
   endfunction

   // Behavioural model: mode 0 = hunting, 1 = checking, 2 = locked.
   int  m_mode = 0;
   bit  hist[$] = '{0, 0, 0, 0};
   int  nseen = 0, run = 0, wpos = 0, werrs = 0;
   bit  m_lock = 0, m_err = 0;
   int  m_cnt = 0;

   function automatic void model(bit d, bit v, bit c, bit r);
      bit pred, miss, any;
      if (!r) begin
         m_mode = 0; hist = '{0, 0, 0, 0};
         nseen = 0; run = 0; wpos = 0; werrs = 0;
         m_lock = 0; m_err = 0; m_cnt = 0;
         return;
      end
      m_err = 0;
      if (v) begin
         pred = hist[3] ^ hist[0];
         miss = (d != pred);
         if (m_mode == 2) begin
            m_err = miss;
            if (miss && m_cnt < CNT_MAX) m_cnt++;
            void'(hist.pop_front());
            hist.push_back(FLY ? pred : d);
            if (miss) werrs++;
            if (werrs >= ERR_MAX) begin
               m_mode = 0; hist = '{0, 0, 0, 0}; nseen = 0;
            end else begin
               wpos++;
               if (wpos == WIN) begin wpos = 0; werrs = 0; end
            end
         end else begin
            void'(hist.pop_front());
            hist.push_back(d);
            if (m_mode == 0) begin
               nseen++;
               any = hist[0] | hist[1] | hist[2] | hist[3];
               if (nseen >= 4 && any) begin m_mode = 1; run = 0; end
            end else begin
               run = miss ? 0 : run + 1;
               if (run == LOCK_CNT) begin m_mode = 2; wpos = 0; werrs = 0; end
            end
         end
      end
      if (c) m_cnt = 0;
      m_lock = (m_mode == 2);
   endfunction

   task automatic step(input bit d, input bit v, input bit c, input bit r);
      exp_t e;
      din = d; din_vld = v; clr = c; res = r;
      model(d, v, c, r);
      e.lock = m_lock; e.err = m_err; e.cnt = m_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) step(gen_bit(), 1'b1, 1'b0, 1'b1);
   endtask

   task automatic flip();
      step(!gen_bit(), 1'b1, 1'b0, 1'b1);
   endtask

   task automatic expect_val(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #3;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (lock !== e.lock || err !== e.err || err_cnt !== 16'(e.cnt)) begin
               n_err++;
               $display("FAIL sb t=%0t: lock/err/err_cnt got %b/%b/%0d, expected %b/%b/%0d",
                        $time, lock, err, err_cnt, e.lock, e.err, e.cnt);
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : driver
      bit rv, rc, rr, rd;
      for (int i = 0; i < 4; i++) pn[i] = 1'b1;
      for (int i = 0; i < 11; i++) pn[i + 4] = pn[i + 3] ^ pn[i];

      // Reset, then a clean stream: lock only after the 12th bit.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      expect_val("rst_lock", int'(lock), 0);
      expect_val("rst_cnt", int'(err_cnt), 0);
      clean(11);
      expect_val("lock_at_11", int'(lock), 0);
      clean(1);
      expect_val("lock_at_12", int'(lock), 1);
      clean(588);
      expect_val("clean_cnt", int'(err_cnt), 0);
      expect_val("clean_lock", int'(lock), 1);

      // One flipped bit while locked.
      clean(3);
      flip();
      clean(10);
      expect_val("flip1_cnt", int'(err_cnt), FLY ? 1 : 3);
      expect_val("flip1_lock", int'(lock), 1);

      // Two flips five apart in a fresh window: fourth error drops lock.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      clean(12);
      expect_val("relock_a", int'(lock), 1);
      clean(1);
      flip();
      clean(4);
      flip();
      expect_val("flip2_lock", int'(lock), FLY ? 1 : 0);
      expect_val("flip2_cnt", int'(err_cnt), FLY ? 2 : 4);
      clean(11);
      expect_val("relock_11", int'(lock), FLY ? 1 : 0);
      clean(1);
      expect_val("relock_12", int'(lock), 1);

      // Constant zero input never locks.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
      expect_val("zeros_lock", int'(lock), 0);

      // Valid on alternate cycles; invalid-cycle din is random noise.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 24; i++) begin
         if (i % 2 == 0) step(gen_bit(), 1'b1, 1'b0, 1'b1);
         else            step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b1);
         if (i == 21) expect_val("vld_lock_21", int'(lock), 0);
         if (i == 22) expect_val("vld_lock_22", int'(lock), 1);
      end

      // clr together with a fresh error, then a single reset edge.
      step(1'b0, 1'b0, 1'b0, 1'b0);
      clean(13);
      flip();
      clean(20);
      expect_val("pre_clr_cnt", int'(err_cnt), FLY ? 1 : 3);
      step(!gen_bit(), 1'b1, 1'b1, 1'b1);
      expect_val("clr_err", int'(err), 1);
      expect_val("clr_cnt", int'(err_cnt), 0);
      clean(5);
      step(gen_bit(), 1'b1, 1'b0, 1'b0);
      expect_val("res_lock", int'(lock), 0);
      expect_val("res_cnt", int'(err_cnt), 0);

      // Randomized traffic: gaps, sparse flips, clears and resets.
      for (int i = 0; i < 3000; i++) begin
         rr = ($urandom_range(499) != 0);
         rv = ($urandom_range(3) != 0);
         rc = ($urandom_range(199) == 0);
         rd = rv ? (gen_bit() ^ ($urandom_range(39) == 0)) : 1'($urandom_range(1));
         step(rd, rv, rc, rr);
      end

      repeat (3) @(posedge clk);
      #4;
      if (sb.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
